// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        jalrE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ResultSrcE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUResultM_fwd,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM
);

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [31:0] pcPlus4;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memWrite;
    logic [1:0]  resultSrc;
  } exMemT;

  logic [31:0] srcA, writeDataE, srcB, aluResult;
  logic        zeroE;
  exMemT       exMem;

  // Forwarding muxes; ALUResultM_fwd is the pre-edge EX/MEM value
  always_comb begin
    unique case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUResultM_fwd;
      default: srcA = RD1_E;
    endcase
    unique case (ForwardBE)
      2'b01:   writeDataE = ResultW;
      2'b10:   writeDataE = ALUResultM_fwd;
      default: writeDataE = RD2_E;
    endcase
    srcB = ALUSrcE ? ImmExtE : writeDataE;
  end

  // ALU; shifts only look at the low five bits of SrcB
  always_comb begin
    unique case (ALUControlE)
      3'b000:  aluResult = srcA + srcB;
      3'b001:  aluResult = srcA - srcB;
      3'b010:  aluResult = srcA & srcB;
      3'b011:  aluResult = srcA | srcB;
      3'b100:  aluResult = srcA ^ srcB;
      3'b101:  aluResult = ($signed(srcA) < $signed(srcB)) ? 32'd1 : 32'd0;
      3'b110:  aluResult = srcA << srcB[4:0];
      default: aluResult = srcA >> srcB[4:0];
    endcase
  end

  // Redirect: beq uses the sub result for zero; jalr clears bit 0 of target
  always_comb begin
    zeroE  = (aluResult == 32'd0);
    PCSrcE = JumpE | (BranchE & zeroE);
    if (jalrE) PCTargetE = (srcA + ImmExtE) & 32'hFFFF_FFFE;
    else       PCTargetE = PCE + ImmExtE;
  end

  // EX/MEM register; async reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exMem <= '0;
    else      exMem <= '{aluResult: aluResult, writeData: writeDataE,
                         pcPlus4: PCPlus4E, rd: RdE, regWrite: RegWriteE,
                         memWrite: MemWriteE, resultSrc: ResultSrcE};
  end

  assign ALUResultM = exMem.aluResult;
  assign WriteDataM = exMem.writeData;
  assign PCPlus4M   = exMem.pcPlus4;
  assign RdM        = exMem.rd;
  assign RegWriteM  = exMem.regWrite;
  assign MemWriteM  = exMem.memWrite;
  assign ResultSrcM = exMem.resultSrc;

endmodule
